serial_receiver_circuit: RTL and testbench

Receiving end of the team's serial link: consumes the bit stream and valid qualifier produced by `serial_transmitter_circuit` and reassembles it into parallel words. The block shifts in `DATA_W` qualified bits MSB-first and aborts frames that stall too long. Each completed word is presented on a one-entry holding register with a valid/ack handshake. It sits between the serial line and the parallel consumer logic.

---
 rtl/serial_receiver_circuit_if.sv | 7 +
 rtl/serial_receiver_circuit.sv | 114 +++++++++++
 tb/tb_serial_receiver_circuit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_receiver_circuit_if.sv
// serial_receiver_circuit_if: serial line input and parallel word handshake of the receiver
interface serial_receiver_circuit_if #(parameter int DATA_W = 8);
    logic serIn, serInValid, dataAck, dataValid, busy, frameErr, overrun, parErr;
    logic [DATA_W-1:0] dataOut;
    modport master (output serIn, serInValid, dataAck, input dataOut, dataValid, busy, frameErr, overrun, parErr);
    modport slave (input serIn, serInValid, dataAck, output dataOut, dataValid, busy, frameErr, overrun, parErr);
endinterface

// File: rtl/serial_receiver_circuit.sv
// serial_receiver_circuit: MSB-first serial-to-parallel receiver with gap abort and one-word holding register
// Define SER_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module serial_receiver_circuit #(
    parameter int DATA_W = 8,
    parameter int GAP_MAX = 4
) (
    input logic clk,
    input logic rst,
    serial_receiver_circuit_if.slave s
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_MAX + 1);
`ifdef SER_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif
    state_t state, state_n;
    logic [DATA_W-1:0] sh, sh_n, word, data_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gap, gap_n;
    logic commit, abort, load, valid_q, ferr_q, ovr_q;
`ifdef SER_RX_PARITY_EN
    logic perr, perr_q;
`endif
    always_comb begin
        state_n = state;
        sh_n = sh;
        cnt_n = cnt;
        gap_n = gap;
        commit = 1'b0;
        abort = 1'b0;
`ifdef SER_RX_PARITY_EN
        perr = 1'b0;
`endif
        word = {sh[DATA_W-2:0], s.serIn};
        if (state == IDLE) begin
            if (s.serInValid) begin
                sh_n = {{(DATA_W-1){1'b0}}, s.serIn};
                cnt_n = CW'(1);
                gap_n = '0;
                state_n = RECV;
            end
        end else if (!s.serInValid) begin
            gap_n = gap + 1'b1;
            if (gap_n == GW'(GAP_MAX)) begin
                abort = 1'b1;
                state_n = IDLE;
                cnt_n = '0;
                gap_n = '0;
            end
        end else begin
            gap_n = '0;
`ifdef SER_RX_PARITY_EN
            if (state == PAR) begin
                word = sh;
                perr = ^{sh, s.serIn};
                commit = ~perr;
                state_n = IDLE;
                cnt_n = '0;
            end else begin
                sh_n = word;
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(DATA_W - 1)) state_n = PAR;
            end
`else
            sh_n = word;
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) begin
                commit = 1'b1;
                state_n = IDLE;
                cnt_n = '0;
            end
`endif
        end
    end
    // a completed word lands only if the holding register is free or being emptied this cycle
    assign load = commit && (!valid_q || s.dataAck);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh <= '0;
            cnt <= '0;
            gap <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            cnt <= cnt_n;
            gap <= gap_n;
            ferr_q <= abort;
            ovr_q <= commit && valid_q && !s.dataAck;
            if (load) data_q <= word;
            valid_q <= load || (valid_q && !s.dataAck);
        end
    end
`ifdef SER_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else perr_q <= perr;
    end
    assign s.parErr = perr_q;
`else
    assign s.parErr = 1'b0;
`endif
    assign s.dataOut = data_q;
    assign s.dataValid = valid_q;
    assign s.busy = state != IDLE;
    assign s.frameErr = ferr_q;
    assign s.overrun = ovr_q;
endmodule

// File: tb/tb_serial_receiver_circuit.sv
// tb_serial_receiver_circuit: directed frame table, hand sequences and randomized traffic against a bit-queue model
module tb_serial_receiver_circuit;
    localparam int DATA_W = 8;
    localparam int GAP_MAX = 4;
`ifdef SER_RX_PARITY_EN
    localparam int FB = DATA_W + 1;
`else
    localparam int FB = DATA_W;
`endif
    typedef struct {
        logic [DATA_W-1:0] word;
        int nbits;
        int gap_at;
        int gap_len;
        bit ack_last;
        bit ack_after;
        logic [DATA_W-1:0] exp_data;
        bit exp_valid;
        bit exp_ferr;
        bit exp_ovr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0, errors = 0;
    bit bits[$];
    int gapc;
    logic [DATA_W-1:0] m_data;
    bit m_valid, m_ferr, m_ovr, m_perr;
    bit seen_ferr, seen_ovr, seen_perr;
    vec_t tbl[7];

    always #5 clk = ~clk;

    serial_receiver_circuit_if #(.DATA_W(DATA_W)) bus ();
    serial_receiver_circuit #(.DATA_W(DATA_W), .GAP_MAX(GAP_MAX)) dut (.clk(clk), .rst(rst), .s(bus));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        gapc = 0;
        m_data = '0;
        m_valid = 0;
        m_ferr = 0;
        m_ovr = 0;
        m_perr = 0;
    endtask

    // frame = the queue of qualified bits since the last completion or abort
    task automatic model_step(bit v, bit b, bit ack);
        bit done = 0;
        int ones = 0;
        logic [DATA_W-1:0] w = '0;
        m_ferr = 0;
        m_ovr = 0;
        m_perr = 0;
        if (v) begin
            bits.push_back(b);
            gapc = 0;
            if (bits.size() == FB) begin
                for (int i = 0; i < DATA_W; i++) w = (w << 1) | DATA_W'(bits[i]);
                foreach (bits[i]) ones += int'(bits[i]);
                done = (FB == DATA_W) || (ones % 2 == 0);
                m_perr = !done;
                bits.delete();
            end
        end else if (bits.size() != 0) begin
            gapc++;
            if (gapc == GAP_MAX) begin
                bits.delete();
                gapc = 0;
                m_ferr = 1;
            end
        end
        if (done && m_valid && !ack) m_ovr = 1;
        else if (done) begin
            m_data = w;
            m_valid = 1;
        end else if (m_valid && ack) m_valid = 0;
    endtask

    task automatic cycle(bit v, bit b, bit ack);
        bus.serInValid = v;
        bus.serIn = b;
        bus.dataAck = ack;
        @(posedge clk);
        model_step(v, b, ack);
        #1;
        chk("dataOut", bus.dataOut, m_data);
        chk("dataValid", bus.dataValid, m_valid);
        chk("busy", bus.busy, bits.size() != 0);
        chk("frameErr", bus.frameErr, m_ferr);
        chk("overrun", bus.overrun, m_ovr);
        chk("parErr", bus.parErr, m_perr);
        seen_ferr |= bus.frameErr;
        seen_ovr |= bus.overrun;
        seen_perr |= bus.parErr;
    endtask

    task automatic send(vec_t t);
        seen_ferr = 0;
        seen_ovr = 0;
        seen_perr = 0;
        for (int i = 0; i < t.nbits; i++) begin
            if (i == t.gap_at) repeat (t.gap_len) cycle(0, 0, 0);
            cycle(1, t.word[DATA_W-1-i], t.ack_last && i == FB - 1);
        end
`ifdef SER_RX_PARITY_EN
        if (t.nbits == DATA_W) cycle(1, ^t.word, t.ack_last);
`endif
        if (t.gap_at == t.nbits) repeat (t.gap_len) cycle(0, 0, 0);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8, -1, 0, 0, 1, 8'hA5, 1, 0, 0};
        tbl[1] = '{8'h3C, 8, 3, 2, 0, 1, 8'h3C, 1, 0, 0};
        tbl[2] = '{8'hFF, 5, 5, 4, 0, 0, 8'h3C, 0, 1, 0};
        tbl[3] = '{8'h0F, 8, -1, 0, 0, 1, 8'h0F, 1, 0, 0};
        tbl[4] = '{8'h11, 8, -1, 0, 0, 0, 8'h11, 1, 0, 0};
        tbl[5] = '{8'h22, 8, -1, 0, 0, 0, 8'h11, 1, 0, 1};
        tbl[6] = '{8'h33, 8, -1, 0, 1, 1, 8'h33, 1, 0, 0};
        rst = 1'b1;
        bus.serIn = 0;
        bus.serInValid = 0;
        bus.dataAck = 0;
        model_reset();
        #2;
        chk("rst_dataOut", bus.dataOut, 0);
        chk("rst_dataValid", bus.dataValid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pulses", {bus.frameErr, bus.overrun, bus.parErr}, 0);
        #10 rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send(tbl[k]);
            chk("tbl_data", bus.dataOut, tbl[k].exp_data);
            chk("tbl_valid", bus.dataValid, tbl[k].exp_valid);
            chk("tbl_ferr", seen_ferr, tbl[k].exp_ferr);
            chk("tbl_ovr", seen_ovr, tbl[k].exp_ovr);
            chk("tbl_busy", bus.busy, 0);
            if (tbl[k].ack_after) begin
                cycle(0, 0, 1);
                chk("ack_clears", bus.dataValid, 0);
                chk("ack_keeps_data", bus.dataOut, tbl[k].exp_data);
            end
        end

        // asynchronous reset in the middle of a frame
        send('{8'hB0, 4, -1, 0, 0, 0, 8'h00, 0, 0, 0});
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_dataOut", bus.dataOut, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.dataValid, 0);
        #2 rst = 1'b0;
        send('{8'h81, 8, -1, 0, 0, 0, 8'h81, 1, 0, 0});
        chk("after_rst_data", bus.dataOut, 8'h81);
        chk("after_rst_valid", bus.dataValid, 1);
        cycle(0, 0, 1);

`ifdef SER_RX_PARITY_EN
        for (int i = 0; i < DATA_W; i++) cycle(1, (8'hA5 >> (DATA_W - 1 - i)) & 1, 0);
        cycle(1, 0, 0);
        chk("par_ok_data", bus.dataOut, 8'hA5);
        chk("par_ok_valid", bus.dataValid, 1);
        cycle(0, 0, 1);
        seen_perr = 0;
        for (int i = 0; i < DATA_W; i++) cycle(1, (8'hA5 >> (DATA_W - 1 - i)) & 1, 0);
        cycle(1, 1, 0);
        chk("par_bad_perr", bus.parErr, 1);
        chk("par_bad_valid", bus.dataValid, 0);
        cycle(0, 0, 0);
        chk("par_pulse_width", bus.parErr, 0);
`endif

        for (int n = 0; n < 3000; n++)
            cycle(($urandom % 8) < 5, $urandom % 2, ($urandom % 4) == 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
